// File: rtl/pe_accumulator.sv
// -----------------------------------------------------------------------------
// pe_accumulator
//   Reduction stage behind the PE multiplier. It sums a stream of signed
//   2*DATA_WIDTH products into a saturating ACC_WIDTH accumulator. prod_last
//   ends each vector (one dot product). The finished sum is presented on a
//   valid/ready port to the requant/writeback stage.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   clear       synchronous flush of all state; outranks every other update
//   prod_valid  product beat valid
//   prod_ready  stage can accept a beat (= !acc_valid || acc_ready)
//   prod_data   signed product, 2*DATA_WIDTH bits
//   prod_last   beat is the final element of the vector
//   acc_valid   result valid; held until accepted
//   acc_ready   downstream accepts the result
//   acc_data    signed saturated vector sum
//   acc_count   number of beats in the vector (saturates at all-ones)
//   acc_ovf     saturation occurred somewhere in this vector
// -----------------------------------------------------------------------------
module pe_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          prod_valid,
  output logic                          prod_ready,
  input  logic signed [2*DATA_WIDTH-1:0] prod_data,
  input  logic                          prod_last,
  output logic                          acc_valid,
  input  logic                          acc_ready,
  output logic signed [ACC_WIDTH-1:0]   acc_data,
  output logic [CNT_WIDTH-1:0]          acc_count,
  output logic                          acc_ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]        CNT_FULL = '1;

  typedef enum logic {
    IDLE  = 1'b0,  // no beat of the current vector taken yet
    ACCUM = 1'b1   // at least one beat taken
  } state_t;

  state_t state, state_next;

  // Running (partial) vector state
  logic signed [ACC_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        ovf;

  // Next-value datapath
  logic signed [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]          wide;
  logic                        clamp;
  logic signed [ACC_WIDTH-1:0] next_sum;
  logic [CNT_WIDTH-1:0]        next_cnt;
  logic                        next_ovf;

  logic beat_fire;
  logic res_fire;
  logic emit;

  assign prod_ready = !acc_valid || acc_ready;
  assign beat_fire  = prod_valid && prod_ready;
  assign res_fire   = acc_valid && acc_ready;
  assign emit       = beat_fire && prod_last;

  // One extra bit of headroom: a disagreement between the top two bits of
  // the widened sum means the true result left the ACC_WIDTH signed range.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    base     = (state == ACCUM) ? sum : '0;
    wide     = {base[ACC_WIDTH-1], base}
             + {{(ACC_WIDTH+1-PW){prod_data[PW-1]}}, prod_data};
    clamp    = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
    next_sum = wide[ACC_WIDTH-1:0];
    if (clamp) begin
      next_sum = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    if (state == IDLE) begin
      next_cnt = CNT_ONE;
    end else if (cnt == CNT_FULL) begin
      next_cnt = cnt;
    end else begin
      next_cnt = cnt + CNT_ONE;
    end
    next_ovf = ((state == ACCUM) && ovf) || clamp;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (beat_fire) begin
      state_next = prod_last ? IDLE : ACCUM;
    end
  end

  // Accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else if (clear) begin
      // Any handshake in this cycle is discarded along with the partial sum.
      sum       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      if (beat_fire) begin
        if (prod_last) begin
          // Running state restarts for the next vector.
          sum <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end else begin
          sum <= next_sum;
          cnt <= next_cnt;
          ovf <= next_ovf;
        end
      end
      // A last beat coinciding with a result accept replaces the old result
      // in the same edge, so acc_valid stays high with no bubble.
      if (emit) begin
        acc_valid <= 1'b1;
        acc_data  <= next_sum;
        acc_count <= next_cnt;
        acc_ovf   <= next_ovf;
      end else if (res_fire) begin
        acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_accumulator.sv
// -----------------------------------------------------------------------------
// tb_pe_accumulator
//   Self-checking bench for pe_accumulator. A default-width instance runs a
//   table of directed beats with hand-computed results; a second instance
//   with ACC_WIDTH=17 exercises saturation. Hand-written sequences cover
//   clear and asynchronous reset in the middle of a vector.
// -----------------------------------------------------------------------------
module tb_pe_accumulator;

  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int AWS = 17;
  localparam int CW  = 16;

  logic                   clk;
  logic                   rst;
  logic                   clear;
  logic                   prod_valid;
  logic signed [2*DW-1:0] prod_data;
  logic                   prod_last;
  logic                   acc_ready;

  logic                   prod_ready;
  logic                   acc_valid;
  logic signed [AW-1:0]   acc_data;
  logic [CW-1:0]          acc_count;
  logic                   acc_ovf;

  logic                   prod_ready_s;
  logic                   acc_valid_s;
  logic signed [AWS-1:0]  acc_data_s;
  logic [CW-1:0]          acc_count_s;
  logic                   acc_ovf_s;

  int checks;
  int failures;

  pe_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_count  (acc_count),
    .acc_ovf    (acc_ovf)
  );

  pe_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AWS), .CNT_WIDTH(CW)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready_s),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .acc_valid  (acc_valid_s),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data_s),
    .acc_count  (acc_count_s),
    .acc_ovf    (acc_ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v;        // prod_valid
    int   d;        // prod_data
    logic l;        // prod_last
    logic r;        // acc_ready
    logic e_pready; // prod_ready before the edge
    logic e_valid;  // acc_valid after the edge
    int   e_data;
    int   e_count;
    logic e_ovf;
  } vec_t;

  function automatic vec_t mk(logic v, int d, logic l, logic r, logic ep,
                              logic ev, int ed, int ec, logic eo);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.e_pready = ep; t.e_valid = ev; t.e_data = ed; t.e_count = ec; t.e_ovf = eo;
    return t;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int d, input logic l, input logic r);
    prod_valid = v;
    prod_data  = (2*DW)'(d);
    prod_last  = l;
    acc_ready  = r;
  endtask

  // Called at posedge+1: apply inputs, check prod_ready, clock, check outputs.
  task automatic run_vec(input string tag, input vec_t t);
    drive(t.v, t.d, t.l, t.r);
    #1;
    check({tag, "_prod_ready"}, 64'(prod_ready), 64'(t.e_pready));
    @(posedge clk);
    #1;
    check({tag, "_acc_valid"}, 64'(acc_valid), 64'(t.e_valid));
    check({tag, "_acc_data"},  $signed(acc_data), 64'(t.e_data));
    check({tag, "_acc_count"}, 64'(acc_count), 64'(t.e_count));
    check({tag, "_acc_ovf"},   64'(acc_ovf), 64'(t.e_ovf));
  endtask

  task automatic step_sat(input string tag, input logic v, input int d,
                          input logic l, input logic ev, input int ed,
                          input int ec, input logic eo);
    drive(v, d, l, 1'b1);
    @(posedge clk);
    #1;
    check({tag, "_acc_valid"}, 64'(acc_valid_s), 64'(ev));
    check({tag, "_acc_data"},  $signed(acc_data_s), 64'(ed));
    check({tag, "_acc_count"}, 64'(acc_count_s), 64'(ec));
    check({tag, "_acc_ovf"},   64'(acc_ovf_s), 64'(eo));
  endtask

  // Safety net: the stimulus is fixed-length, so this only trips on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear    = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc_valid", 64'(acc_valid), 64'd0);
    check("rst_acc_data",  $signed(acc_data), 64'd0);
    check("rst_acc_count", 64'(acc_count), 64'd0);
    check("rst_acc_ovf",   64'(acc_ovf), 64'd0);
    check("rst_prod_ready", 64'(prod_ready), 64'd1);
    rst = 1'b0;

    // Saturation at ACC_WIDTH=17: 3*32767 exceeds 65535
    step_sat("sat_b0", 1'b1, 32767, 1'b0, 1'b0, 0, 0, 1'b0);
    step_sat("sat_b1", 1'b1, 32767, 1'b0, 1'b0, 0, 0, 1'b0);
    step_sat("sat_b2", 1'b1, 32767, 1'b1, 1'b1, 65535, 3, 1'b1);
    step_sat("sat_nx", 1'b1, 1,     1'b1, 1'b1, 1, 1, 1'b0);
    step_sat("sat_id", 1'b0, 0,     1'b0, 1'b0, 1, 1, 1'b0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    //            v   d       l  r   | pr ev  data    cnt ovf
    // 3 + -5 + 7, result visible for exactly one cycle
    tbl.push_back(mk(1, 3,      0, 1,  1, 0, 0,      0, 0));
    tbl.push_back(mk(1, -5,     0, 1,  1, 0, 0,      0, 0));
    tbl.push_back(mk(1, 7,      1, 1,  1, 1, 5,      3, 0));
    tbl.push_back(mk(0, 0,      0, 1,  1, 0, 5,      3, 0));
    // Single most-negative product
    tbl.push_back(mk(1, -32768, 1, 1,  1, 1, -32768, 1, 0));
    tbl.push_back(mk(0, 0,      0, 1,  1, 0, -32768, 1, 0));
    // Back-to-back 1-beat vectors, no bubbles
    tbl.push_back(mk(1, 1,      1, 1,  1, 1, 1,      1, 0));
    tbl.push_back(mk(1, 2,      1, 1,  1, 1, 2,      1, 0));
    tbl.push_back(mk(1, 3,      1, 1,  1, 1, 3,      1, 0));
    tbl.push_back(mk(0, 0,      0, 1,  1, 0, 3,      1, 0));
    // Backpressure: A=10 held, B beats stall until A is accepted
    tbl.push_back(mk(1, 10,     1, 0,  1, 1, 10,     1, 0));
    tbl.push_back(mk(1, 1,      0, 0,  0, 1, 10,     1, 0));
    tbl.push_back(mk(1, 1,      0, 0,  0, 1, 10,     1, 0));
    tbl.push_back(mk(1, 1,      0, 1,  1, 0, 10,     1, 0));
    tbl.push_back(mk(1, 2,      0, 0,  1, 0, 10,     1, 0));
    tbl.push_back(mk(1, 3,      1, 0,  1, 1, 6,      3, 0));
    tbl.push_back(mk(1, 9,      1, 0,  0, 1, 6,      3, 0));
    tbl.push_back(mk(0, 0,      0, 1,  1, 0, 6,      3, 0));
    // prod_data/prod_last ignored without prod_valid
    tbl.push_back(mk(0, 77,     1, 1,  1, 0, 6,      3, 0));
    tbl.push_back(mk(1, 4,      1, 1,  1, 1, 4,      1, 0));
    tbl.push_back(mk(0, 0,      0, 1,  1, 0, 4,      1, 0));

    foreach (tbl[i]) run_vec($sformatf("row%0d", i), tbl[i]);

    // Clear mid-vector drops the partial sum and a same-cycle last beat
    run_vec("clr_b0", mk(1, 4, 0, 1, 1, 0, 4, 1, 0));
    run_vec("clr_b1", mk(1, 4, 0, 1, 1, 0, 4, 1, 0));
    drive(1'b1, 100, 1'b1, 1'b1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_acc_valid", 64'(acc_valid), 64'd0);
    run_vec("clr_nx", mk(1, 9, 1, 1, 1, 1, 9, 1, 0));
    run_vec("clr_id", mk(0, 0, 0, 1, 1, 0, 9, 1, 0));

    // Async reset mid-vector: outputs drop with no clock edge
    run_vec("ar_b0", mk(1, 4, 0, 1, 1, 0, 9, 1, 0));
    run_vec("ar_b1", mk(1, 4, 0, 1, 1, 0, 9, 1, 0));
    drive(1'b0, 0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_acc_valid", 64'(acc_valid), 64'd0);
    check("ar_acc_data",  $signed(acc_data), 64'd0);
    check("ar_acc_count", 64'(acc_count), 64'd0);
    check("ar_acc_ovf",   64'(acc_ovf), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec("ar_nx", mk(1, 9, 1, 1, 1, 1, 9, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
